// File: rtl/rc_pulse_train.sv
// Serial R/C servo pulse-train generator: one pulse per channel each frame, slew-limited, ARM-gated.
// Outputs registered one cycle behind the frame counter; free-running, no backpressure.
module rc_pulse_train #(
  parameter int N_CH        = 2,
  parameter int MAG_W       = 3,
  parameter int FRAME_CYC   = 1200000,
  parameter int NEUTRAL_CYC = 150000,
  parameter int STEP_CYC    = 3125,
  parameter int GAP_CYC     = 120000,
  parameter int SLEW_CYC    = 0,
  localparam int CW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      ARM,
  input  logic [N_CH*(MAG_W+2)-1:0] CMD,
  output logic                      PWM,
  output logic                      FRAME_STB,
  output logic                      PULSE_ACT,
  output logic [CW-1:0]             CH_IDX
);

  localparam int CMD_W = MAG_W + 2;
  localparam int CNT_W = $clog2(FRAME_CYC);
  localparam int WW    = $clog2(FRAME_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_CYC - 1);
  localparam logic [WW-1:0]    NEUTRAL_W = WW'(NEUTRAL_CYC);
  localparam logic [WW-1:0]    STEP_W    = WW'(STEP_CYC);
  localparam logic [WW-1:0]    GAP_W     = WW'(GAP_CYC);
  localparam logic [WW-1:0]    SLEW_W    = WW'(SLEW_CYC);
  localparam logic [CW-1:0]    LAST_CH   = CW'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t           state_q, state_d;
  logic [WW-1:0]    timer_q, timer_d;
  logic [CW-1:0]    ch_q, ch_d, ch_inc;
  logic             pend_q, pend_d;
  logic             pwm_q, pwm_d;
  logic             stb_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WW-1:0]    applied_q [N_CH];

  function automatic logic [WW-1:0] decode_width(input logic [CMD_W-1:0] c);
    logic [WW-1:0] delta;
    delta = STEP_W * (WW'(c[CMD_W-1:2]) + WW'(1));
    case (c[1:0])
      2'b00:   decode_width = NEUTRAL_W + delta;
      2'b10:   decode_width = NEUTRAL_W - delta;
      default: decode_width = NEUTRAL_W;
    endcase
  endfunction

  // Move at most SLEW_W toward the target; a zero slew limit means jump straight there.
  function automatic logic [WW-1:0] slew_toward(input logic [WW-1:0] cur,
                                                input logic [WW-1:0] tgt);
    logic [WW-1:0] diff;
    if (SLEW_CYC == 0) begin
      slew_toward = tgt;
    end else if (tgt >= cur) begin
      diff        = tgt - cur;
      slew_toward = (diff > SLEW_W) ? cur + SLEW_W : tgt;
    end else begin
      diff        = cur - tgt;
      slew_toward = (diff > SLEW_W) ? cur - SLEW_W : tgt;
    end
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Commands are only looked at on the last cycle of a frame, so a frame never changes mid-flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_CH; i++) applied_q[i] <= NEUTRAL_W;
    end else if (cnt_q == CNT_LAST) begin
      for (int i = 0; i < N_CH; i++) begin
        applied_q[i] <= ARM ? slew_toward(applied_q[i], decode_width(CMD[i*CMD_W +: CMD_W]))
                            : NEUTRAL_W;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ch_d    = ch_q;
    pend_d  = pend_q;
    pwm_d   = 1'b0;
    ch_inc  = ch_q + CW'(1);
    if (cnt_q == '0) begin
      // A wrap that catches the sequence mid-flight idles one cycle, then restarts at ch0.
      if (state_q != IDLE) begin
        state_d = IDLE;
        pend_d  = 1'b1;
      end else begin
        state_d = PULSE;
        ch_d    = '0;
        timer_d = applied_q[0] - WW'(1);
        pwm_d   = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_q) begin
            state_d = PULSE;
            ch_d    = '0;
            timer_d = applied_q[0] - WW'(1);
            pwm_d   = 1'b1;
            pend_d  = 1'b0;
          end
        end
        PULSE: begin
          if (timer_q == '0) begin
            if (ch_q < LAST_CH) begin
              state_d = GAP;
              timer_d = GAP_W - WW'(1);
            end else begin
              state_d = IDLE;
            end
          end else begin
            timer_d = timer_q - WW'(1);
            pwm_d   = 1'b1;
          end
        end
        GAP: begin
          if (timer_q == '0) begin
            state_d = PULSE;
            ch_d    = ch_inc;
            timer_d = applied_q[ch_inc] - WW'(1);
            pwm_d   = 1'b1;
          end else begin
            timer_d = timer_q - WW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      timer_q <= '0;
      ch_q    <= '0;
      pend_q  <= 1'b0;
      pwm_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ch_q    <= ch_d;
      pend_q  <= pend_d;
      pwm_q   <= pwm_d;
      stb_q   <= (cnt_q == '0);
    end
  end

  assign PWM       = pwm_q;
  assign PULSE_ACT = pwm_q;
  assign FRAME_STB = stb_q;
  assign CH_IDX    = ch_q;

endmodule
